// File: rtl/video_types.sv
// Shared video-subsystem types: register addresses, OAM sizing and the OAM DMA state encoding.
package video_types;

  localparam logic [15:0] OAM_DMA_ADDR = 16'hFF46;
  localparam int          OAM_SIZE     = 160;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RD    = 3'd2,
    CAP   = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } DmaState;

  // Echo RAM pages E0-FF alias WRAM C0-DF.
  function automatic logic [7:0] echo_remap(input logic [7:0] page);
    return (page >= 8'hE0) ? page - 8'h20 : page;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to FF46 copies XFER_LEN bytes from {src,8'h00} into OAM at DEST_BASE.
// Build option OAM_DMA_ECHO_REMAP_EN redirects echo-RAM source pages to WRAM.
module oam_dma
  import video_types::*;
#(
  parameter int          XFER_LEN  = OAM_SIZE,
  parameter logic [15:0] DEST_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        m_req,
  input  logic        m_gnt,
  output logic [15:0] m_addr,
  output logic        m_rd,
  output logic        m_wr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  output logic        dma_active,
  output logic        dma_done,
  output logic [2:0]  dbg_state
);

  DmaState    state_q, state_d;
  logic [7:0] src_q;
  logic [7:0] idx_q;
  logic [7:0] data_q;
  logic [7:0] src_eff;
  logic       last_byte;

`ifdef OAM_DMA_ECHO_REMAP_EN
  assign src_eff = echo_remap(src_q);
`else
  assign src_eff = src_q;
`endif

  assign last_byte = (idx_q == 8'(XFER_LEN - 1));
  assign reg_rdata = src_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (reg_wr)
        src_q <= reg_wdata;
      if (state_q == START)
        idx_q <= 8'h00;
      else if (state_q == WR && m_gnt)
        idx_q <= idx_q + 8'd1;
      // Read data returns the cycle after the accepted read, which is always CAP.
      if (state_q == CAP)
        data_q <= m_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      START:   state_d = RD;
      RD:      if (m_gnt) state_d = CAP;
      CAP:     state_d = WR;
      WR:      if (m_gnt) state_d = last_byte ? DONE : RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new FF46 write restarts the copy and suppresses a pending completion.
    if (reg_wr)
      state_d = START;
  end

  // Bus handshake: m_req holds while a byte is in flight; a read or write takes
  // effect only in a cycle with m_gnt=1, and m_rd/m_wr are asserted exactly then.
  // Address and write data are driven only alongside their strobe, otherwise 0.
  always_comb begin
    m_req      = 1'b0;
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    m_addr     = 16'h0000;
    m_wdata    = 8'h00;
    dma_active = 1'b0;
    dma_done   = 1'b0;
    case (state_q)
      START: dma_active = 1'b1;
      RD: begin
        m_req      = 1'b1;
        dma_active = 1'b1;
        m_rd       = m_gnt;
        if (m_gnt)
          m_addr = {src_eff, idx_q};
      end
      CAP: begin
        m_req      = 1'b1;
        dma_active = 1'b1;
      end
      WR: begin
        m_req      = 1'b1;
        dma_active = 1'b1;
        m_wr       = m_gnt;
        if (m_gnt) begin
          m_addr  = DEST_BASE + 16'(idx_q);
          m_wdata = data_q;
        end
      end
      DONE:    dma_done = 1'b1;
      default: ;
    endcase
  end

endmodule
